aes_test_sequencer: RTL
=======================

AES_TEST_SEQUENCER -- requirements
Module: aes_test_sequencer

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 4096: max cycles waited for Kvld or Dvld before abort.
REQ-002 SHALL provide parameter GAP_CYC, default 4: idle cycles with EN low between consecutive runs.
REQ-003 SHALL have port CLK, input, 1: single clock for all logic.
REQ-004 SHALL have port RST, input, 1: reset, synchronous to CLK, active-high.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a campaign.
REQ-006 SHALL have ports key_in, pt_in and exp_in, each input, 128: key, plaintext and expected ciphertext.
REQ-007 SHALL have port num_runs, input, 16: number of encryptions per campaign.
REQ-008 SHALL have ports Kin and Din, each output, 128: key and plaintext driven to the AES/DRAM top.
REQ-009 SHALL have ports Kdrdy and EN, each output, 1: key strobe and encryption enable driven to the AES/DRAM top.
REQ-010 SHALL have ports Dout (input, 128), Kvld, Dvld and Dload (each input, 1): results from the AES/DRAM top.
REQ-011 SHALL have ports busy and done, each output, 1: campaign active and campaign finished (one-cycle pulse).
REQ-012 SHALL have ports pass_cnt and fail_cnt, each output, 16: comparison tallies.
REQ-013 SHALL have ports dload_cnt (output, 16: Dload pulses in the campaign) and last_ct (output, 128: last captured Dout).
REQ-014 SHALL have port timeout_err, output, 1: sticky abort flag.

Function
REQ-015 SHALL implement FSM states IDLE, KEY_LOAD, KEY_WAIT, DATA_LOAD, DATA_WAIT, CHECK, GAP and FIN.
- IDLE -> KEY_LOAD on start.
- If num_runs==0: IDLE -> FIN.
REQ-016 KEY_LOAD SHALL last one cycle with Kdrdy=1 and Kin=key_in, then go to KEY_WAIT.
REQ-017 KEY_WAIT SHALL go to DATA_LOAD on the first cycle Kvld==1, counting from the cycle after Kdrdy.
REQ-018 EN SHALL be 1 from DATA_LOAD through DATA_WAIT, and 0 in every other state.
REQ-019 Din SHALL remain stable for as long as EN==1.
REQ-020 DATA_WAIT SHALL capture Dout into last_ct on the first cycle Dvld==1, then go to CHECK.
REQ-021 CHECK SHALL last one cycle.
- Increment pass_cnt if last_ct==exp_in, else fail_cnt.
- Go to GAP if runs remain, else FIN.
REQ-022 GAP SHALL hold for GAP_CYC cycles and then go to DATA_LOAD, so the key is loaded only once per campaign.
REQ-023 While busy, dload_cnt SHALL increment on every cycle Dload==1.
REQ-024 All counters SHALL saturate at 16'hFFFF and never wrap.
REQ-025 A wait counter SHALL clear on entry to KEY_WAIT or DATA_WAIT.
- On reaching TIMEOUT_CYC: set timeout_err, drop EN, go to FIN.
REQ-026 If Dvld (or Kvld) and the timeout occur in the same cycle, valid SHALL win and no timeout is flagged.
REQ-027 FIN SHALL pulse done for one cycle, then go to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 start SHALL be ignored while busy.
REQ-030 In IDLE, start SHALL clear pass_cnt, fail_cnt, dload_cnt and timeout_err.
REQ-031 Counts, last_ct and timeout_err SHALL hold their values in IDLE until the next start.

Reset
REQ-032 When RST=1 at a CLK edge, the FSM SHALL go to IDLE.
REQ-033 Reset SHALL drive every output to 0: EN, Kdrdy, busy, done, counters, last_ct, timeout_err, Kin, Din.
REQ-034 RST asserted mid-run SHALL drop EN and Kdrdy on the next edge, with no done pulse.

Configuration
REQ-035 With AES_SEQ_CHAIN_EN defined: Din for run n+1 SHALL be the last_ct of run n, and Din for run 0 SHALL be pt_in.
REQ-036 With AES_SEQ_CHAIN_EN defined: only the final run SHALL be compared, updating pass_cnt or fail_cnt once per campaign; intermediate CHECKs only advance.
REQ-037 Without AES_SEQ_CHAIN_EN: Din SHALL equal pt_in for every run, and every run SHALL be compared.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, default TIMEOUT_CYC/GAP_CYC constants and the 128-bit block typedef.
REQ-039 One sub-module, aes_seq_timeout (loadable wait counter with expiry flag), SHALL be instantiated once.

Verification
REQ-040 Use key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, exp 69c4e0d86a7b0430d8cdb78070b4c55a, num_runs=3, with a DUT model answering correctly.
- Require pass_cnt=3, fail_cnt=0, one Kdrdy pulse, three EN windows separated by 4 low cycles, and done once.
REQ-041 Use the same setup with exp flipped in bit 0.
- Require pass_cnt=0, fail_cnt=3, and last_ct=69c4...c55a.
REQ-042 Have the model never assert Dvld, with TIMEOUT_CYC=16.
- Require EN to fall at the 16th wait cycle, timeout_err=1, done pulse, and fail_cnt=0.
REQ-043 Start with num_runs=0.
- Require done two cycles after start, all counts 0, and EN never high.
REQ-044 Assert RST during DATA_WAIT of run 2.
- Require EN=0 and all counts 0 the next cycle, no done pulse, and a following start that runs cleanly.
REQ-045 With AES_SEQ_CHAIN_EN defined and num_runs=2, run 2 Din SHALL equal run 1 ciphertext; only the final run counts, giving pass_cnt+fail_cnt=1.

Source files
------------

// File: rtl/aes_test_sequencer_pkg.sv
// aes_test_sequencer_pkg: shared FSM states, default timing constants, block type and saturating increment
package aes_test_sequencer_pkg;
   localparam int unsigned TIMEOUT_CYC_DEF = 4096;
   localparam int unsigned GAP_CYC_DEF     = 4;
   typedef logic [127:0] block_t;
   typedef enum logic [2:0] {IDLE, KEY_LOAD, KEY_WAIT, DATA_LOAD, DATA_WAIT, CHECK, GAP, FIN} state_t;
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/aes_test_sequencer_timeout.sv
// aes_seq_timeout: clearable wait counter that flags expiry on its LIMIT-th enabled cycle
// Ports: clk, rst (sync, active-high), clr_i (restart count), en_i (count this cycle), expired_o
module aes_seq_timeout #(
   parameter int unsigned LIMIT = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int unsigned W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk) begin
      if (rst || clr_i) cnt_q <= '0;
      else if (en_i && !expired_o) cnt_q <= cnt_q + W'(1);
   end
   assign expired_o = en_i && (cnt_q == W'(LIMIT - 1));
endmodule

// File: rtl/aes_test_sequencer.sv
// aes_test_sequencer: drives an AES/DRAM top through a campaign of encryptions and tallies results
// Ports: CLK/RST (sync, active-high); start, key_in, pt_in, exp_in, num_runs (campaign setup);
//        Kin, Din, Kdrdy, EN (to AES top); Dout, Kvld, Dvld, Dload (from AES top);
//        busy, done, pass_cnt, fail_cnt, dload_cnt, last_ct, timeout_err (status).
// Build option: AES_SEQ_CHAIN_EN feeds each run's ciphertext into the next run and compares only the last.
module aes_test_sequencer
   import aes_test_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int unsigned GAP_CYC     = GAP_CYC_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  block_t      key_in,
   input  block_t      pt_in,
   input  block_t      exp_in,
   input  logic [15:0] num_runs,
   output block_t      Kin,
   output block_t      Din,
   output logic        Kdrdy,
   output logic        EN,
   input  block_t      Dout,
   input  logic        Kvld,
   input  logic        Dvld,
   input  logic        Dload,
   output logic        busy,
   output logic        done,
   output logic [15:0] pass_cnt,
   output logic [15:0] fail_cnt,
   output logic [15:0] dload_cnt,
   output block_t      last_ct,
   output logic        timeout_err
);
   state_t      state_q, state_d;
   logic [15:0] pass_q, fail_q, dload_q, rem_q, gap_q;
   block_t      last_q, din_q;
   logic        tout_q, done_q, expired, last_run, cmp;

   aes_seq_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
      .clk      (CLK),
      .rst      (RST),
      .clr_i    (state_q == KEY_LOAD || state_q == DATA_LOAD),
      .en_i     (state_q == KEY_WAIT || state_q == DATA_WAIT),
      .expired_o(expired)
   );

   assign last_run = rem_q <= 16'd1;
`ifdef AES_SEQ_CHAIN_EN
   assign cmp = last_run;
`else
   assign cmp = 1'b1;
`endif

   // CHECK is the first EN-low cycle between runs, so GAP itself lasts GAP_CYC-1 cycles
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (start) state_d = (num_runs == '0) ? FIN : KEY_LOAD;
         KEY_LOAD:  state_d = KEY_WAIT;
         KEY_WAIT:  state_d = Kvld ? DATA_LOAD : (expired ? FIN : KEY_WAIT);
         DATA_LOAD: state_d = DATA_WAIT;
         DATA_WAIT: state_d = Dvld ? CHECK : (expired ? FIN : DATA_WAIT);
         CHECK:     state_d = last_run ? FIN : ((GAP_CYC > 1) ? GAP : DATA_LOAD);
         GAP:       state_d = (gap_q == 16'(GAP_CYC - 2)) ? DATA_LOAD : GAP;
         FIN:       state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         pass_q  <= '0;
         fail_q  <= '0;
         dload_q <= '0;
         rem_q   <= '0;
         gap_q   <= '0;
         last_q  <= '0;
         din_q   <= '0;
         tout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= state_q == FIN;
         gap_q   <= (state_q == GAP) ? gap_q + 16'd1 : '0;
         if (state_q == IDLE && start) begin
            pass_q  <= '0;
            fail_q  <= '0;
            dload_q <= '0;
            tout_q  <= 1'b0;
            rem_q   <= num_runs;
         end
         if (state_q != IDLE && Dload) dload_q <= sat_inc(dload_q);
         if (state_q == DATA_WAIT && Dvld) last_q <= Dout;
         // a valid arriving on the expiry cycle takes priority over the abort
         if (expired && !(state_q == KEY_WAIT ? Kvld : Dvld)) tout_q <= 1'b1;
         if (state_q == CHECK) begin
            rem_q <= rem_q - 16'd1;
            if (cmp && last_q == exp_in) pass_q <= sat_inc(pass_q);
            if (cmp && last_q != exp_in) fail_q <= sat_inc(fail_q);
         end
`ifdef AES_SEQ_CHAIN_EN
         if (state_q == IDLE && start) din_q <= pt_in;
         else if (state_q == CHECK) din_q <= last_q;
`else
         if (state_d == DATA_LOAD) din_q <= pt_in;
`endif
      end
   end

   assign Kdrdy       = state_q == KEY_LOAD;
   assign Kin         = Kdrdy ? key_in : '0;
   assign EN          = state_q == DATA_LOAD || state_q == DATA_WAIT;
   assign Din         = din_q;
   assign busy        = state_q != IDLE;
   assign done        = done_q;
   assign pass_cnt    = pass_q;
   assign fail_cnt    = fail_q;
   assign dload_cnt   = dload_q;
   assign last_ct     = last_q;
   assign timeout_err = tout_q;
endmodule
